conv1d_3tap: RTL and testbench
==============================

// Module: conv1d_3tap
// PURPOSE
//  Pipelined 3-tap 1-D convolution engine (unsigned, small-width) for the Lab convolution chain.
//  Directly downstream of the stimulus driver: consumes its 4-bit sample stream and kernel
//  coefficients, and produces the 10-bit result that the driver prints.
//  result = k0*d0 + k1*d1 + k2*d2, where d0 is the newest accepted sample and d2 the oldest.
// PARAMETERS
//  DATA_W   4   sample width, unsigned
//  COEF_W   4   coefficient width, unsigned
//  RES_W    10  result width; must satisfy RES_W >= DATA_W+COEF_W+2 (elaboration-time check)
//  K0_INIT  1   reset value of coefficient register k0
//  K1_INIT  3   reset value of coefficient register k1
//  K2_INIT  1   reset value of coefficient register k2
// PORTS
//  clk          in   1       clock, rising edge; driver changes inputs away from the rising edge
//  rst          in   1       synchronous reset, active-high
//  in_valid     in   1       data is a new sample this cycle
//  data         in   DATA_W  input sample
//  flush        in   1       synchronous clear of the sample window; coefficients are kept
//  kernel_load  in   1       load kernel_0..2 into the coefficient registers
//  kernel_0     in   COEF_W  coefficient k0, applied to the newest sample
//  kernel_1     in   COEF_W  coefficient k1
//  kernel_2     in   COEF_W  coefficient k2, applied to the oldest sample
//  result       out  RES_W   convolution result, registered
//  out_valid    out  1       one-cycle strobe: result is valid
// BEHAVIOUR
//  Reset (rst=1 at a clock edge): window d0..d2=0, fill=0, product and stage valids=0,
//   result=0, out_valid=0, k0/k1/k2=K*_INIT. Reset overrides every other input.
//  Stage W, the window: on an edge with in_valid=1, d2<=d1, d1<=d0, d0<=data,
//   fill<=min(fill+1,3). With in_valid=0 the window holds. vW is asserted when a sample
//   was accepted and the new fill == 3.
//  Stage P, the products: p_i <= k_i*d_i at full DATA_W+COEF_W width; vP <= vW.
//  Stage S, the sum: result <= zero-extended p0+p1+p2; out_valid <= vP.
//  Latency: a sample accepted at edge E gives its result and out_valid after edge E+2.
//   Throughput is one result per cycle. Gaps in in_valid produce matching gaps in out_valid.
//  result holds its last value while out_valid=0 (it is not cleared).
//  Warm-up: the first 2 accepted samples after reset or flush produce no out_valid.
//  Kernel: on an edge with kernel_load=1, k_i <= kernel_i.
//   Stage P always uses the k_i values from before the edge.
//   kernel_load and in_valid in the same cycle: that sample's products use the old kernel.
//  Flush: at the edge, window=0, fill=0, vW=0. In-flight stages P and S still complete
//   (up to 2 trailing out_valid pulses).
//  flush and in_valid together: flush wins and the sample is dropped.
//  Arithmetic: no overflow by construction. Max = 3*(2^DATA_W-1)*(2^COEF_W-1) = 675 with defaults.
// STRUCTURE
//  Package conv_pkg holds DATA_W/COEF_W/RES_W defaults, default kernel constants {1,3,1},
//   and the derived PROD_W = DATA_W+COEF_W.
//  Sub-module conv_window: window shift register, fill counter, vW.
//   Ports: clk, rst, flush, in_valid, data -> d0, d1, d2, vW.
//  The top level holds the coefficient registers, stage P and stage S.
// TESTING
//  1 Reset, default kernel 1,3,1; drive 2,4,6 on consecutive cycles -> out_valid once,
//    result=20, two edges after the 6 is accepted.
//  2 Continue from 1 with 8, then 10 -> results 30, 40 on consecutive cycles.
//  3 kernel_load 15,15,15; three samples of 15 -> result=675 (max, no wrap).
//  4 Insert 3 idle cycles between samples -> no out_valid during the gap; the next result
//    uses the held window, e.g. 2,4,[gap],6 -> 20.
//  5 flush after 2,4, then 6,8 -> no out_valid; then 1 -> result=1*1+3*8+6=31.
//  6 rst asserted mid-stream with vP=1 -> out_valid=0 and result=0 after the edge;
//    kernel back to 1,3,1; warm-up restarts.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: default widths and kernel for the 3-tap convolution engine
package conv_pkg;
   localparam int DEF_DATA_W = 4;
   localparam int DEF_COEF_W = 4;
   localparam int DEF_RES_W  = 10;
   localparam int DEF_PROD_W = DEF_DATA_W + DEF_COEF_W;
   localparam int DEF_K0     = 1;
   localparam int DEF_K1     = 3;
   localparam int DEF_K2     = 1;
   // Narrowest result that holds three full-width products without wrapping
   function automatic int min_res_w(input int dw, input int cw);
      return dw + cw + 2;
   endfunction
endpackage

// File: rtl/conv_window.sv
// conv_window: 3-sample shift window with fill counter and window-full strobe
module conv_window import conv_pkg::*; #(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] data,
   output logic [DATA_W-1:0] d0,
   output logic [DATA_W-1:0] d1,
   output logic [DATA_W-1:0] d2,
   output logic              vW
);
   logic [DATA_W-1:0] d0_q, d1_q, d2_q, d0_d, d1_d, d2_d;
   logic [1:0]        fill_q, fill_d;
   logic              vw_q, vw_d, take;
   // Flush beats a simultaneous sample; fill saturates at 3
   always_comb begin
      take   = in_valid && !flush;
      fill_d = flush ? 2'd0 : (take && fill_q != 2'd3) ? fill_q + 2'd1 : fill_q;
      d0_d   = flush ? '0 : take ? data : d0_q;
      d1_d   = flush ? '0 : take ? d0_q : d1_q;
      d2_d   = flush ? '0 : take ? d1_q : d2_q;
      vw_d   = take && fill_d == 2'd3;
   end
   // Window state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         d0_q   <= '0;
         d1_q   <= '0;
         d2_q   <= '0;
         fill_q <= 2'd0;
         vw_q   <= 1'b0;
      end else begin
         d0_q   <= d0_d;
         d1_q   <= d1_d;
         d2_q   <= d2_d;
         fill_q <= fill_d;
         vw_q   <= vw_d;
      end
   end
   assign d0 = d0_q;
   assign d1 = d1_q;
   assign d2 = d2_q;
   assign vW = vw_q;
endmodule

// File: rtl/conv1d_3tap.sv
// conv1d_3tap: pipelined 3-tap unsigned convolution, window -> products -> sum
module conv1d_3tap import conv_pkg::*; #(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int COEF_W  = DEF_COEF_W,
   parameter int RES_W   = DEF_RES_W,
   parameter int K0_INIT = DEF_K0,
   parameter int K1_INIT = DEF_K1,
   parameter int K2_INIT = DEF_K2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] data,
   input  logic              flush,
   input  logic              kernel_load,
   input  logic [COEF_W-1:0] kernel_0,
   input  logic [COEF_W-1:0] kernel_1,
   input  logic [COEF_W-1:0] kernel_2,
   output logic [RES_W-1:0]  result,
   output logic              out_valid
);
   localparam int PROD_W = DATA_W + COEF_W;
   if (RES_W < min_res_w(DATA_W, COEF_W)) begin : g_res_w_chk
      $error("conv1d_3tap: RES_W too narrow for DATA_W+COEF_W+2");
   end
   logic [DATA_W-1:0] d0, d1, d2;
   logic              vw;
   logic [COEF_W-1:0] k0_q, k1_q, k2_q, k0_d, k1_d, k2_d;
   logic [COEF_W-1:0] kw0_q, kw1_q, kw2_q;
   logic [PROD_W-1:0] p0_q, p1_q, p2_q, p0_d, p1_d, p2_d;
   logic              vp_q, ov_q;
   logic [RES_W-1:0]  res_q, res_d;
   conv_window #(.DATA_W(DATA_W)) u_window (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .in_valid (in_valid),
      .data     (data),
      .d0       (d0),
      .d1       (d1),
      .d2       (d2),
      .vW       (vw)
   );
   // kw*_q is the kernel in force when the current window was shifted, so a sample
   // arriving together with kernel_load is still weighted by the old coefficients
   always_comb begin
      k0_d  = kernel_load ? kernel_0 : k0_q;
      k1_d  = kernel_load ? kernel_1 : k1_q;
      k2_d  = kernel_load ? kernel_2 : k2_q;
      p0_d  = PROD_W'(kw0_q) * PROD_W'(d0);
      p1_d  = PROD_W'(kw1_q) * PROD_W'(d1);
      p2_d  = PROD_W'(kw2_q) * PROD_W'(d2);
      res_d = vp_q ? RES_W'(p0_q) + RES_W'(p1_q) + RES_W'(p2_q) : res_q;
   end
   // Coefficients, product stage and sum stage; result holds between strobes
   always_ff @(posedge clk) begin
      if (rst) begin
         k0_q  <= COEF_W'(K0_INIT);
         k1_q  <= COEF_W'(K1_INIT);
         k2_q  <= COEF_W'(K2_INIT);
         kw0_q <= COEF_W'(K0_INIT);
         kw1_q <= COEF_W'(K1_INIT);
         kw2_q <= COEF_W'(K2_INIT);
         p0_q  <= '0;
         p1_q  <= '0;
         p2_q  <= '0;
         vp_q  <= 1'b0;
         res_q <= '0;
         ov_q  <= 1'b0;
      end else begin
         k0_q  <= k0_d;
         k1_q  <= k1_d;
         k2_q  <= k2_d;
         kw0_q <= k0_q;
         kw1_q <= k1_q;
         kw2_q <= k2_q;
         p0_q  <= p0_d;
         p1_q  <= p1_d;
         p2_q  <= p2_d;
         vp_q  <= vw;
         res_q <= res_d;
         ov_q  <= vp_q;
      end
   end
   assign result    = res_q;
   assign out_valid = ov_q;
endmodule

// File: tb/tb_conv1d_3tap.sv
// tb_conv1d_3tap: scoreboard bench with a sample-history reference model
module tb_conv1d_3tap;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       in_valid = 1'b0;
   logic [3:0] data = 4'd0;
   logic       flush = 1'b0;
   logic       kernel_load = 1'b0;
   logic [3:0] kernel_0 = 4'd0;
   logic [3:0] kernel_1 = 4'd0;
   logic [3:0] kernel_2 = 4'd0;
   logic [9:0] result;
   logic       out_valid;

   typedef struct {
      int val;
      int due;
   } exp_t;

   exp_t sbq[$];
   int   hist[$];
   int   k[3];
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   last_res = 0;
   bit   started = 1'b0;
   exp_t e;

   conv1d_3tap dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .data        (data),
      .flush       (flush),
      .kernel_load (kernel_load),
      .kernel_0    (kernel_0),
      .kernel_1    (kernel_1),
      .kernel_2    (kernel_2),
      .result      (result),
      .out_valid   (out_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: newest-first list of samples since reset/flush; the kernel used is
   // the one held before the edge that accepted the sample
   task automatic model();
      if (rst) begin
         hist.delete();
         sbq.delete();
         k = '{1, 3, 1};
         last_res = 0;
      end else begin
         if (flush) hist.delete();
         else if (in_valid) begin
            hist.push_front(int'(data));
            if (hist.size() > 3) void'(hist.pop_back());
            if (hist.size() == 3)
               sbq.push_back('{val: k[0]*hist[0] + k[1]*hist[1] + k[2]*hist[2], due: cyc + 2});
         end
         if (kernel_load) k = '{int'(kernel_0), int'(kernel_1), int'(kernel_2)};
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      model();
      #1;
      rst = 1'b0;
      in_valid = 1'b0;
      flush = 1'b0;
      kernel_load = 1'b0;
   endtask

   task automatic samp(input int d);
      data = 4'(d);
      in_valid = 1'b1;
      tick();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic kset(input int a, input int b, input int c);
      kernel_load = 1'b1;
      kernel_0 = 4'(a);
      kernel_1 = 4'(b);
      kernel_2 = 4'(c);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      started = 1'b1;
      chk("reset_out_valid", int'(out_valid), 0);
      chk("reset_result", int'(result), 0);
   endtask

   // Monitor: every strobe must match the oldest pending expectation on its due cycle;
   // between strobes result must hold
   always @(negedge clk) begin
      if (started) begin
         while (sbq.size() > 0 && sbq[0].due < cyc) begin
            e = sbq.pop_front();
            chk("missed_out_valid", 0, e.val);
         end
         if (out_valid) begin
            if (sbq.size() == 0) chk("spurious_out_valid", int'(result), -1);
            else begin
               e = sbq.pop_front();
               chk("result", int'(result), e.val);
               chk("latency", cyc, e.due);
            end
            last_res = int'(result);
         end else chk("result_hold", int'(result), last_res);
      end
   end

   initial begin
      rst = 1'b1;
      tick();
      do_reset();
      samp(2); samp(4); samp(6); idle(2);
      chk("t1_result", int'(result), 20);
      samp(8); samp(10); idle(2);
      chk("t2_result", int'(result), 40);
      kset(15, 15, 15); tick();
      samp(15); samp(15); samp(15); idle(2);
      chk("t3_max", int'(result), 675);
      do_reset();
      samp(2); samp(4); idle(3); samp(6); idle(2);
      chk("t4_gap", int'(result), 20);
      flush = 1'b1; tick();
      samp(2); samp(4);
      flush = 1'b1; data = 4'd9; in_valid = 1'b1; tick();
      samp(6); samp(8); samp(1); idle(2);
      chk("t5_flush", int'(result), 31);
      kset(2, 2, 2); samp(7); idle(2);
      chk("same_cycle_kernel", int'(result), 18);
      samp(5); idle(1);
      rst = 1'b1; tick();
      chk("t6_out_valid", int'(out_valid), 0);
      chk("t6_result", int'(result), 0);
      samp(1); samp(2); samp(3); idle(2);
      chk("t6_kernel_restored", int'(result), 10);
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 199) == 0);
         flush = ($urandom_range(0, 19) == 0);
         in_valid = ($urandom_range(0, 3) != 0);
         data = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 15) == 0)
            kset($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
         tick();
      end
      idle(4);
      chk("drain", sbq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
